// File: rtl/cpu_load_sequencer.sv
// Program loader for the nibble-serial CPU: buffers {op, data, last} entries, replays them after a CPU reset, then runs.
// Define LOADER_CHECKSUM_EN to build the 8-bit running sum of issued data nibbles on `checksum`.
//
// state | meaning
// IDLE  | parked, CPU bus quiet, waiting for start
// RST   | one-cycle CPU reset pulse, clears load_count/checksum
// ARM   | waits for a full FIFO or a last-tagged entry
// LOAD  | one FIFO entry per cycle onto the CPU bus
// RUN   | RUNPROG burst, down-counter from latched run_cycles
// DONE  | burst finished, CPU held in reset
// ERR   | FIFO ran dry before a last-tagged entry, CPU held in reset

module cpu_load_sequencer #(
    parameter int DEPTH = 8,
    parameter int RUN_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [3:0]       in_data,
    input  logic             in_last,
    input  logic             start,
    input  logic             abort,
    input  logic [RUN_W-1:0] run_cycles,
    output logic [1:0]       cpu_instr,
    output logic [3:0]       cpu_data,
    output logic             cpu_reset,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [7:0]       load_count,
    output logic [7:0]       checksum
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {S_IDLE, S_RST, S_ARM, S_LOAD, S_RUN, S_DONE, S_ERR} state_t;

    state_t            state, state_nxt;
    logic [6:0]        mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count, last_cnt;
    logic              full, empty, push, pop;
    logic [6:0]        head;
    logic              cur_last;
    logic [RUN_W-1:0]  run_len, run_cnt;
    logic [1:0]        instr_nxt;
    logic [3:0]        data_nxt;
    logic              reset_nxt;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign in_ready = !full;
    assign push     = in_valid && in_ready;
    assign head     = mem[rd_ptr];

    assign busy  = (state == S_RST) || (state == S_ARM) || (state == S_LOAD) || (state == S_RUN);
    assign done  = (state == S_DONE);
    assign error = (state == S_ERR);

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= {in_op, in_data, in_last};
    end

    // last_cnt tracks how many last-tagged entries are buffered, so ARM needs no FIFO scan.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            last_cnt <= '0;
        end else if (abort) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            last_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            count    <= count + CW'(push) - CW'(pop);
            last_cnt <= last_cnt + CW'(push && in_last) - CW'(pop && head[0]);
        end
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        if (abort) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE, S_DONE, S_ERR: if (start) state_nxt = S_RST;
                S_RST: state_nxt = S_ARM;
                S_ARM: begin
                    if (full || last_cnt != '0) begin
                        pop       = 1'b1;
                        state_nxt = S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (cur_last)    state_nxt = S_RUN;
                    else if (!empty) pop = 1'b1;
                    else             state_nxt = S_ERR;
                end
                S_RUN: if (run_cnt == RUN_W'(1)) state_nxt = S_DONE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // CPU bus values are decided by the state being entered, so they appear registered with it.
    always_comb begin
        instr_nxt = 2'd0;
        data_nxt  = 4'd0;
        reset_nxt = 1'b0;
        case (state_nxt)
            S_RST, S_DONE, S_ERR: reset_nxt = 1'b1;
            S_LOAD: begin
                instr_nxt = head[6:5];
                data_nxt  = head[4:1];
            end
            S_RUN:   instr_nxt = 2'd3;
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            cpu_instr  <= 2'd0;
            cpu_data   <= 4'd0;
            cpu_reset  <= 1'b0;
            cur_last   <= 1'b0;
            run_len    <= '0;
            run_cnt    <= '0;
            load_count <= 8'd0;
        end else begin
            state     <= state_nxt;
            cpu_instr <= instr_nxt;
            cpu_data  <= data_nxt;
            cpu_reset <= reset_nxt;
            if (pop) cur_last <= head[0];
            if (state_nxt == S_RST) run_len <= run_cycles;
            if (state == S_LOAD && state_nxt == S_RUN)
                run_cnt <= run_len;
            else if (state == S_RUN && run_cnt != '0)
                run_cnt <= run_cnt - RUN_W'(1);
            if (state == S_RST)
                load_count <= 8'd0;
            else if (pop && load_count != 8'hFF)
                load_count <= load_count + 8'd1;
        end
    end

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] sum_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)              sum_q <= 8'd0;
        else if (state == S_RST) sum_q <= 8'd0;
        else if (pop)            sum_q <= sum_q + {4'd0, head[4:1]};
    end

    assign checksum = sum_q;
`else
    assign checksum = 8'd0;
`endif

endmodule
